// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared execute-stage ALU.
// It serves two requesters, one operation in flight at a time, with registered operands and response.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_cout,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_cout,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero
);

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(4'b1100);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              grant;
  logic              accept;
  logic              legal;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] result_q;
  logic              cout_q, zero_q, err_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    legal = 1'b0;
    case (ctrl_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid =  owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched on accept; the ALU outputs are sampled once, in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        op_a_q       <= grant ? req1_a    : req0_a;
        op_b_q       <= grant ? req1_b    : req0_b;
        ctrl_q       <= grant ? req1_ctrl : req0_ctrl;
      end
      if (state_q == EXEC) begin
        result_q <= legal ? alu_result : '0;
        cout_q   <= legal && alu_cout;
        zero_q   <= legal && alu_zero;
        err_q    <= !legal;
      end
    end
  end

  assign alu_op1     = op_a_q;
  assign alu_op2     = op_b_q;
  assign alu_ctrl    = ctrl_q;
  assign rsp0_result = result_q;
  assign rsp0_cout   = cout_q;
  assign rsp0_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_result = result_q;
  assign rsp1_cout   = cout_q;
  assign rsp1_zero   = zero_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_alu_arbiter;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100;
  localparam logic [3:0] C_BAD = 4'b0011;

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp0_cout, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_cout, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_cout, alu_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   grant_log[$];
  int   acc_log[$];
  int   acc_cyc0, acc_cyc1, rsp_start0, rsp_start1, hs_cyc1;
  logic prev_v0 = 1'b0, prev_v1 = 1'b0;
  exp_t mon_e;

  alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_cout(rsp0_cout), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_cout(rsp1_cout), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; illegal codes return junk so the arbiter must mask it.
  always_comb begin
    logic [32:0] s;
    s = 33'd0;
    case (alu_ctrl)
      C_AND: s = {1'b0, alu_op1 & alu_op2};
      C_OR:  s = {1'b0, alu_op1 | alu_op2};
      C_ADD: s = {1'b0, alu_op1} + {1'b0, alu_op2};
      C_SUB: s = {1'b0, alu_op1} - {1'b0, alu_op2};
      C_NOR: s = {1'b0, ~(alu_op1 | alu_op2)};
      C_SLT: s = {32'd0, alu_op1 < alu_op2};
      default: s = {1'b1, 32'hDEADBEEF};
    endcase
    alu_result = s[31:0];
    alu_cout   = s[32];
    alu_zero   = (alu_op1 == alu_op2);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Monitor: records accepts and compares each response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) begin grant_log.push_back(0); acc_log.push_back(cyc); acc_cyc0 = cyc; end
      if (req1_valid && req1_ready) begin grant_log.push_back(1); acc_log.push_back(cyc); acc_cyc1 = cyc; end
      if (rsp0_valid && !prev_v0) rsp_start0 = cyc;
      if (rsp1_valid && !prev_v1) rsp_start1 = cyc;
      if (rsp0_valid && rsp1_valid) failNow("rsp_both_valid", "got both valid, expected one");
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q0.size() == 0) failNow("rsp0_unexpected", "got response, expected none");
        else begin
          mon_e = exp_q0.pop_front();
          checkOutput("rsp0_result", rsp0_result, mon_e.result);
          checkOutput("rsp0_cout", rsp0_cout, mon_e.cout);
          checkOutput("rsp0_zero", rsp0_zero, mon_e.zero);
          checkOutput("rsp0_err", rsp0_err, mon_e.err);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        hs_cyc1 = cyc;
        if (exp_q1.size() == 0) failNow("rsp1_unexpected", "got response, expected none");
        else begin
          mon_e = exp_q1.pop_front();
          checkOutput("rsp1_result", rsp1_result, mon_e.result);
          checkOutput("rsp1_cout", rsp1_cout, mon_e.cout);
          checkOutput("rsp1_zero", rsp1_zero, mon_e.zero);
          checkOutput("rsp1_err", rsp1_err, mon_e.err);
        end
      end
      prev_v0 = rsp0_valid;
      prev_v1 = rsp1_valid;
    end
  end

  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] ctrl, input bit expect_rsp,
                               input logic [31:0] r, input bit c, input bit z, input bit e);
    int  waited = 0;
    bit  done   = 0;
    exp_t x;
    x = '{result: r, cout: c, zero: z, err: e};
    if (expect_rsp) begin
      if (port == 0) exp_q0.push_back(x);
      else           exp_q1.push_back(x);
    end
    if (port == 0) begin req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_valid = 1'b1; end
    else           begin req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_valid = 1'b1; end
    while (!done && waited < 100) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) done = 1;
      else waited++;
    end
    if (!done) failNow("accept_timeout", "got no ready, expected ready within 100 cycles");
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp0_valid || rsp1_valid) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) failNow("drain_timeout", "got pending responses, expected none after 100 cycles");
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string name);
    checkOutput(name, {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0000);
  endtask

  task automatic checkResetOutputs(input string name);
    checkQuiet(name);
    checkOutput({name, "_alu_op1"}, alu_op1, 32'd0);
    checkOutput({name, "_alu_op2"}, alu_op2, 32'd0);
    checkOutput({name, "_alu_ctrl"}, alu_ctrl, 4'd0);
    checkOutput({name, "_result"}, rsp0_result, 32'd0);
    checkOutput({name, "_flags"}, {rsp0_cout, rsp0_zero, rsp0_err, rsp1_cout, rsp1_zero, rsp1_err}, 6'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset values, then ten quiet cycles with no requests.
    #3;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkQuiet("idle_quiet");
    end
    @(posedge clk);
    #1;

    // Tie: both requesters valid continuously; grants alternate starting at 0.
    grant_log.delete();
    acc_log.delete();
    fork
      begin
        applyStimulus(0, 32'hF0, 32'h0F, C_OR, 1, 32'hFF, 0, 0, 0);
        applyStimulus(0, 32'hFF, 32'h0F, C_AND, 1, 32'h0F, 0, 0, 0);
      end
      begin
        applyStimulus(1, 32'd3, 32'd3, C_SUB, 1, 32'd0, 0, 1, 0);
        applyStimulus(1, 32'd0, 32'd0, C_NOR, 1, 32'hFFFFFFFF, 0, 1, 0);
      end
    join
    waitDrain();
    checkOutput("tie_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("tie_grant_order", grant_log[i], i % 2);
      for (int i = 0; i < 3; i++) checkOutput("tie_accept_spacing", acc_log[i+1] - acc_log[i], 3);
    end

    // Single ADD on requester 0 with latency check.
    applyStimulus(0, 32'd5, 32'd7, C_ADD, 1, 32'd12, 0, 0, 0);
    waitDrain();
    checkOutput("single_latency", rsp_start0 - acc_cyc0, 2);

    // Wrap-around carries and unsigned compare.
    applyStimulus(0, 32'd0, 32'd1, C_SUB, 1, 32'hFFFFFFFF, 1, 0, 0);
    applyStimulus(1, 32'hFFFFFFFF, 32'd1, C_ADD, 1, 32'd0, 1, 0, 0);
    applyStimulus(0, 32'd2, 32'd9, C_SLT, 1, 32'd1, 0, 0, 0);
    applyStimulus(1, 32'd9, 32'd2, C_SLT, 1, 32'd0, 0, 0, 0);
    waitDrain();

    // Illegal op under backpressure; requester 0 waits behind it.
    rsp1_ready = 1'b0;
    applyStimulus(1, 32'd5, 32'd5, C_BAD, 1, 32'd0, 0, 0, 1);
    fork
      applyStimulus(0, 32'd10, 32'd20, C_ADD, 1, 32'd30, 0, 0, 0);
      begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("bp_rsp1_valid", rsp1_valid, 1'b1);
          checkOutput("bp_rsp1_result", rsp1_result, 32'd0);
          checkOutput("bp_rsp1_flags", {rsp1_cout, rsp1_zero, rsp1_err}, 3'b001);
          checkOutput("bp_req0_ready", req0_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp1_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_req0_accept_cycle", acc_cyc0, hs_cyc1 + 1);

    // Asynchronous reset while the operation is in EXEC.
    applyStimulus(0, 32'd1, 32'd2, C_ADD, 0, 32'd0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    checkOutput("async_reset_alu_op2_seen", alu_op2, 32'd0);
    repeat (2) @(negedge clk);
    checkResetOutputs("reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkQuiet("post_reset_quiet");
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 32'd1, 32'd1, C_ADD, 1, 32'd2, 0, 1, 0);
    waitDrain();
    checkOutput("reissue_latency", rsp_start0 - acc_cyc0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 32-bit ALU in the execute stage. It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the combinational ALU from registered operands and returns the registered result, carry, zero and error flags on a per-requester response channel. One operation is in flight at a time.

## Interface
- DATA_W, 32, operand/result width (ALU is 32-bit; fixed at 32 in this design)
- CTRL_W, 4, ALU control code width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request valid, N = 0, 1
- reqN_ready  out  1  request accepted this cycle
- reqN_a, reqN_b  in  DATA_W  operands
- reqN_ctrl  in  CTRL_W  ALU control code
- rspN_valid  out  1  response valid
- rspN_ready  in  1  requester accepts response
- rspN_result  out  DATA_W  registered ALU result
- rspN_cout, rspN_zero, rspN_err  out  1  carry/borrow, equality flag, illegal-op flag
- alu_op1, alu_op2  out  DATA_W  to ALU operands
- alu_ctrl  out  CTRL_W  to ALU control
- alu_result  in  DATA_W  from ALU (combinational)
- alu_cout, alu_zero  in  1  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP. Reset values:
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - Operand, ctrl and result registers are 0.
  - All reqN_ready and rspN_valid are 0.
- IDLE arbitration:
  - Only one reqN_valid is high: grant N.
  - Both are high: grant the requester that is not last_grant.
  - reqN_ready = (state == IDLE) && granted N. This is combinational from the valids.
- Accept (valid && ready):
  - Latch a, b, ctrl into op_a_q, op_b_q, ctrl_q.
  - Latch the owner index.
  - Set last_grant = N.
  - Go to EXEC.
- alu_op1 / alu_op2 / alu_ctrl are always op_a_q / op_b_q / ctrl_q. The ALU only ever sees registered values.
- EXEC: capture alu_result, alu_cout and alu_zero into the response registers. Go to RESP.
- Legal ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT (unsigned compare).
- Illegal ctrl code:
  - The captured result is 0, cout = 0, zero = 0, err = 1.
  - The ALU is still driven, but its outputs are ignored.
- Legal ctrl code: err = 0. zero is the ALU equality flag (op_a == op_b), not result == 0.
- RESP behaviour:
  - rsp{owner}_valid = 1. The other rsp valid is 0.
  - The response fields are shared registers, presented on both ports. Requesters qualify them with their own rspN_valid.
  - On rsp{owner}_ready, go to IDLE.
- Requesters hold valid, a, b and ctrl stable until ready. The arbiter never retracts ready within a cycle in which valid is held.

## Timing
- Latency:
  - Accept at edge T.
  - EXEC occupies cycle T+1 and registers its capture at edge T+1.
  - rspN_valid is high from cycle T+2.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with ready already high. The next accept is the cycle after the RESP handshake, in IDLE. There is no accept while in EXEC or RESP.
- Backpressure: while in RESP and rspN_ready = 0, rspN_valid and all response fields hold stable indefinitely. Other requests wait.
- A new request from the requester just served may be presented during RESP. It is arbitrated in IDLE against the other requester, and the other requester wins if both are valid.
- Carry: ADD/SUB carry is bit 32 of the 33-bit sum/difference. SUB with a < b gives cout = 1 (e.g. 0 − 1 = FFFFFFFF, cout 1).
- Reset mid-operation: rst_n low immediately forces the reset values asynchronously.
  - An in-flight request or pending response is dropped with no response, and requesters reissue.
  - Outputs stay at reset values until the first rising clk after rst_n deasserts.

## Test plan
- Reset: with rst_n low, all outputs are 0 and state is IDLE. After release with no valids, nothing asserts for 10 cycles.
- Single op: req0 ADD a=5, b=7 at T -> req0_ready at T; rsp0_valid from T+2 with result=12, cout=0, zero=0, err=0.
- Tie and fairness: req0 and req1 both valid continuously, ops OR 0xF0|0x0F and SUB 3−3.
  - Grants alternate 0,1,0,1.
  - rsp1 shows result=0, zero=1, cout=0.
  - Accepts are spaced 3 cycles apart.
- Wrap and SLT:
  - SUB 0−1 -> result=FFFFFFFF, cout=1.
  - ADD FFFFFFFF+1 -> result=0, cout=1.
  - SLT 2<9 -> result=1.
- Backpressure and illegal op: req1 ctrl=0011 with rsp1_ready held low 5 cycles -> rsp1_valid, result=0 and err=1 stay stable; req0 is not accepted until the cycle after rsp1_ready rises.
- Async reset during EXEC: rst_n pulses low mid-cycle -> all outputs drop immediately and no response is produced. A reissued ADD 1+1 after release returns 2 at accept+2.
